// File: rtl/seq_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module      : seq_magnitude_comparator
// Description : Multi-cycle unsigned magnitude comparator; one 4-bit stage
//               scans NIBBLES nibbles MSB-first. EARLY_EXIT_EN stops the scan
//               on the first unequal nibble.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_magnitude_comparator #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic                   a_lt_b,
    output logic                   a_eq_b,
    output logic                   a_gt_b
);

    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] c_idx_msb = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [4*NIBBLES-1:0]   r_a;
    logic [4*NIBBLES-1:0]   r_b;
    logic [IDXW-1:0]        r_idx;
    logic                   r_lt;
    logic                   r_eq;
    logic                   r_gt;

    logic [4*NIBBLES-1:0]   w_a_shift;
    logic [4*NIBBLES-1:0]   w_b_shift;
    logic [3:0]             w_nib_a;
    logic [3:0]             w_nib_b;
    logic                   w_nib_lt;
    logic                   w_nib_gt;
    logic                   w_nib_ne;
    logic                   w_last;
    logic                   w_finish;
    logic                   w_res_lt;
    logic                   w_res_eq;
    logic                   w_res_gt;

    // Shared 4-bit comparator stage fed by the currently selected nibble
    assign w_a_shift = r_a >> {r_idx, 2'b00};
    assign w_b_shift = r_b >> {r_idx, 2'b00};
    assign w_nib_a   = w_a_shift[3:0];
    assign w_nib_b   = w_b_shift[3:0];
    assign w_nib_lt  = (w_nib_a < w_nib_b);
    assign w_nib_gt  = (w_nib_a > w_nib_b);
    assign w_nib_ne  = w_nib_lt | w_nib_gt;
    assign w_last    = (r_idx == '0);

`ifdef EARLY_EXIT_EN
    assign w_finish  = w_nib_ne | w_last;
    assign w_res_lt  = w_nib_lt;
    assign w_res_gt  = w_nib_gt;
    assign w_res_eq  = ~w_nib_ne;
`else
    logic r_decided;
    logic r_dec_lt;
    logic r_dec_gt;

    // First mismatch from the MSB wins; later nibbles cannot override it
    assign w_finish  = w_last;
    assign w_res_lt  = r_decided ? r_dec_lt : w_nib_lt;
    assign w_res_gt  = r_decided ? r_dec_gt : w_nib_gt;
    assign w_res_eq  = ~r_decided & ~w_nib_ne;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_decided <= 1'b0;
            r_dec_lt  <= 1'b0;
            r_dec_gt  <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_decided <= 1'b0;
            r_dec_lt  <= 1'b0;
            r_dec_gt  <= 1'b0;
        end else if (r_state == S_COMPARE && !r_decided && w_nib_ne) begin
            r_decided <= 1'b1;
            r_dec_lt  <= w_nib_lt;
            r_dec_gt  <= w_nib_gt;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_COMPARE;
            S_COMPARE: if (w_finish) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= '0;
            r_lt  <= 1'b0;
            r_eq  <= 1'b0;
            r_gt  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_idx <= c_idx_msb;
                    end
                end
                S_COMPARE: begin
                    // Flags change only on the edge that enters DONE
                    if (w_finish) begin
                        r_lt <= w_res_lt;
                        r_eq <= w_res_eq;
                        r_gt <= w_res_gt;
                    end else if (!w_last) begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state == S_COMPARE);
    assign done   = (r_state == S_DONE);
    assign a_lt_b = r_lt;
    assign a_eq_b = r_eq;
    assign a_gt_b = r_gt;

endmodule
`default_nettype wire
